// File: rtl/lsu_pkg.sv
// Shared encodings for the data-side load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP1,
        S_ACCESS1,
        S_SETUP2,
        S_ACCESS2,
        S_RESP
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane math: two-beat strobe mask, shifted store data and extended load data.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int B  = DATA_WIDTH / 8,
    localparam int OW = $clog2(B)
) (
    input  logic [OW-1:0]           off,
    input  logic [1:0]              size,
    input  logic                    is_unsigned,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [2*DATA_WIDTH-1:0] rbuf,
    output logic [2*B-1:0]          mask,
    output logic [2*DATA_WIDTH-1:0] wdata_sh,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    misaligned
);

    int unsigned             offi;
    int unsigned             nbytes;
    logic [2*DATA_WIDTH-1:0] sh;
    logic                    sgn;

    always_comb begin
        offi   = 32'(off);
        nbytes = 32'd1 << size;
        for (int unsigned i = 0; i < 2 * B; i++) begin
            mask[i] = (i >= offi) && (i < offi + nbytes);
        end
        misaligned = |mask[2*B-1:B];
        wdata_sh   = {{DATA_WIDTH{1'b0}}, wdata} << (offi * 8);

        sh = rbuf >> (offi * 8);
        case (size)
            SZ_B:    sgn = sh[7];
            SZ_H:    sgn = sh[15];
            SZ_W:    sgn = sh[31];
            default: sgn = sh[DATA_WIDTH-1];
        endcase
        sgn = sgn & ~is_unsigned;
        // A full-width load copies every byte, so the fill never applies to it.
        for (int unsigned i = 0; i < B; i++) begin
            rdata[i*8 +: 8] = (i < nbytes) ? sh[i*8 +: 8] : {8{sgn}};
        end
    end

endmodule

// File: rtl/apb_lsu.sv
// Load/store unit: one CPU request becomes one or two APB master transfers.
module apb_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT          = 255,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                    clk,
    input  logic                    rts,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   APB_paddr,
    output logic [DATA_WIDTH-1:0]   APB_pdata,
    input  logic [DATA_WIDTH-1:0]   APB_prdata,
    output logic                    APB_psel,
    output logic                    APB_penable,
    output logic                    APB_pwrite,
    output logic [DATA_WIDTH/8-1:0] APB_pstb,
    input  logic                    APB_pready,
    input  logic                    APB_perr
);

    localparam int B  = DATA_WIDTH / 8;
    localparam int OW = $clog2(B);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t                  state, nxt;
    logic                    wr_q, uns_q, err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, base;
    logic [1:0]              size_q, a_size;
    logic [OW-1:0]           a_off;
    logic [DATA_WIDTH-1:0]   wdata_q, rext;
    logic [2*DATA_WIDTH-1:0] rbuf_q, wsh;
    logic [2*B-1:0]          mask;
    logic                    mis, illegal, beat2, time_hit;
    logic [CW-1:0]           cnt_q;
    logic [CW:0]             cnt_inc;

    // In IDLE the aligner sees the incoming request so the reject decision is immediate.
    assign a_off  = (state == S_IDLE) ? req_addr[OW-1:0] : addr_q[OW-1:0];
    assign a_size = (state == S_IDLE) ? req_size : size_q;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .off        (a_off),
        .size       (a_size),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .rbuf       (rbuf_q),
        .mask       (mask),
        .wdata_sh   (wsh),
        .rdata      (rext),
        .misaligned (mis)
    );

    assign illegal  = (req_size == SZ_D) && (DATA_WIDTH < 64);
    assign base     = {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}};
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
    assign time_hit = (TIMEOUT != 0) && (cnt_inc == (CW+1)'(TIMEOUT));

    always_comb begin
        nxt   = state;
        err_d = err_q;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (illegal || (mis && (SPLIT_MISALIGNED == 0))) begin
                        nxt   = S_RESP;
                        err_d = 1'b1;
                    end else begin
                        nxt   = S_SETUP1;
                        err_d = 1'b0;
                    end
                end
            end
            S_SETUP1: nxt = S_ACCESS1;
            S_SETUP2: nxt = S_ACCESS2;
            S_ACCESS1: begin
                if (APB_pready) begin
                    if (APB_perr) begin
                        nxt   = S_RESP;
                        err_d = 1'b1;
                    end else begin
                        nxt = mis ? S_SETUP2 : S_RESP;
                    end
                end else if (time_hit) begin
                    nxt   = S_RESP;
                    err_d = 1'b1;
                end
            end
            S_ACCESS2: begin
                if (APB_pready) begin
                    nxt   = S_RESP;
                    err_d = APB_perr;
                end else if (time_hit) begin
                    nxt   = S_RESP;
                    err_d = 1'b1;
                end
            end
            S_RESP:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == S_IDLE);
        APB_psel    = (state == S_SETUP1) || (state == S_ACCESS1) ||
                      (state == S_SETUP2) || (state == S_ACCESS2);
        APB_penable = (state == S_ACCESS1) || (state == S_ACCESS2);
        beat2       = (state == S_SETUP2) || (state == S_ACCESS2);
        APB_pwrite  = APB_psel && wr_q;
        APB_paddr   = '0;
        APB_pdata   = '0;
        APB_pstb    = '0;
        if (APB_psel) begin
            APB_paddr = beat2 ? base + ADDR_WIDTH'(B) : base;
            if (wr_q) begin
                APB_pdata = beat2 ? wsh[2*DATA_WIDTH-1:DATA_WIDTH] : wsh[DATA_WIDTH-1:0];
                APB_pstb  = beat2 ? mask[2*B-1:B] : mask[B-1:0];
            end else begin
                APB_pstb = '1;
            end
        end
        resp_valid = (state == S_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !wr_q) ? rext : '0;
    end

    always_ff @(posedge clk or posedge rts) begin
        if (rts) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state <= nxt;
            err_q <= err_d;
            if (state == S_IDLE && req_valid) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= req_wdata;
                rbuf_q  <= '0;
            end
            if (nxt == S_SETUP1 || nxt == S_SETUP2) begin
                cnt_q <= '0;
            end else if (APB_penable && !APB_pready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state == S_ACCESS1 && APB_pready && !wr_q) begin
                rbuf_q[DATA_WIDTH-1:0] <= APB_prdata;
            end
            if (state == S_ACCESS2 && APB_pready && !wr_q) begin
                rbuf_q[2*DATA_WIDTH-1:DATA_WIDTH] <= APB_prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_lsu.sv
// Directed bench for apb_lsu: main unit (TIMEOUT=4, split on) plus a no-split instance.
module tb_apb_lsu;

    logic        clk = 1'b0;
    logic        rts;
    logic        rv, rv_ns;
    logic        req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, APB_paddr, APB_pdata, APB_prdata;
    logic        APB_psel, APB_penable, APB_pwrite, APB_pready, APB_perr;
    logic [3:0]  APB_pstb;

    logic        ns_req_ready, ns_resp_valid, ns_resp_err;
    logic [31:0] ns_resp_rdata, ns_paddr, ns_pdata;
    logic        ns_psel, ns_penable, ns_pwrite;
    logic [3:0]  ns_pstb;

    logic        rdy_base, stall_hi, perr_en, use_ns;
    logic [31:0] rd_lo, rd_hi;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign APB_pready = rdy_base & ~(stall_hi & APB_paddr[2]);
    assign APB_perr   = perr_en;
    assign APB_prdata = APB_paddr[2] ? rd_hi : rd_lo;

    apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .SPLIT_MISALIGNED(1)) dut (
        .clk(clk), .rts(rts), .req_valid(rv), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .APB_paddr(APB_paddr), .APB_pdata(APB_pdata), .APB_prdata(APB_prdata),
        .APB_psel(APB_psel), .APB_penable(APB_penable), .APB_pwrite(APB_pwrite),
        .APB_pstb(APB_pstb), .APB_pready(APB_pready), .APB_perr(APB_perr)
    );

    apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255), .SPLIT_MISALIGNED(0)) dut_ns (
        .clk(clk), .rts(rts), .req_valid(rv_ns), .req_ready(ns_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
        .APB_paddr(ns_paddr), .APB_pdata(ns_pdata), .APB_prdata(APB_prdata),
        .APB_psel(ns_psel), .APB_penable(ns_penable), .APB_pwrite(ns_pwrite),
        .APB_pstb(ns_pstb), .APB_pready(APB_pready), .APB_perr(APB_perr)
    );

    logic        c_ready, c_valid, c_err;
    logic [31:0] c_rdata;
    assign c_ready = use_ns ? ns_req_ready  : req_ready;
    assign c_valid = use_ns ? ns_resp_valid : resp_valid;
    assign c_err   = use_ns ? ns_resp_err   : resp_err;
    assign c_rdata = use_ns ? ns_resp_rdata : resp_rdata;

    // Bus monitor, sampled on the falling edge where everything is settled.
    logic [31:0] xa[64];
    logic [31:0] xd[64];
    logic [3:0]  xs[64];
    int nx = 0, n_setup = 0, n_acc = 0, n_ns_sel = 0;

    always @(negedge clk) begin
        if (APB_psel && APB_penable && APB_pready) begin
            xa[nx % 64] = APB_paddr;
            xd[nx % 64] = APB_pdata;
            xs[nx % 64] = APB_pstb;
            nx++;
        end
        if (APB_psel && !APB_penable) n_setup++;
        if (APB_psel && APB_penable) n_acc++;
        if (ns_psel || ns_penable) n_ns_sel++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns, input logic on_ns,
                           output int lat, output logic [31:0] rd, output logic err);
        req_write    = wr;
        req_addr     = a;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
        use_ns       = on_ns;
        #0;
        check("ready_before", c_ready, 1);
        if (on_ns) rv_ns = 1'b1; else rv = 1'b1;
        @(posedge clk); #1;
        rv = 1'b0; rv_ns = 1'b0;
        lat = 1;
        while (!c_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!c_valid) check("resp_wait", 0, 1);
        rd  = c_rdata;
        err = c_err;
        @(posedge clk); #1;
        check("resp_one_cycle", c_valid, 0);
    endtask

    int          lat, x0, s0, a0, k;
    logic [31:0] rd;
    logic        err;

    initial begin
        rts = 1'b1; rv = 1'b0; rv_ns = 1'b0; use_ns = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        rdy_base = 1'b1; stall_hi = 1'b0; perr_en = 1'b0;
        rd_lo = '0; rd_hi = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_psel", {APB_psel, APB_penable, APB_pwrite}, 0);
        check("rst_resp", {resp_valid, resp_err}, 0);
        check("rst_pstb", APB_pstb, 0);
        rts = 1'b0;
        @(posedge clk); #1;

        // aligned lw
        rd_lo = 32'hDEADBEEF;
        x0 = nx;
        run_req(0, 32'h8000_0000, 0, 2'd2, 0, 0, lat, rd, err);
        check("lw_lat", lat, 3);
        check("lw_data", rd, 32'hDEADBEEF);
        check("lw_err", err, 0);
        check("lw_nx", nx - x0, 1);
        check("lw_addr", xa[x0 % 64], 32'h8000_0000);
        check("lw_stb", xs[x0 % 64], 4'b1111);

        // sb to top lane
        x0 = nx;
        run_req(1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 0, 0, lat, rd, err);
        check("sb_lat", lat, 3);
        check("sb_nx", nx - x0, 1);
        check("sb_addr", xa[x0 % 64], 32'h8000_0000);
        check("sb_stb", xs[x0 % 64], 4'b1000);
        check("sb_data", xd[x0 % 64], 32'hA500_0000);
        check("sb_rdata", rd, 0);

        // split signed lh
        rd_lo = 32'h8000_0000; rd_hi = 32'h0000_0012;
        x0 = nx;
        run_req(0, 32'h8000_0003, 0, 2'd1, 0, 0, lat, rd, err);
        check("lh_lat", lat, 5);
        check("lh_nx", nx - x0, 2);
        check("lh_addr1", xa[x0 % 64], 32'h8000_0000);
        check("lh_addr2", xa[(x0 + 1) % 64], 32'h8000_0004);
        check("lh_stb2", xs[(x0 + 1) % 64], 4'b1111);
        check("lh_data", rd, 32'h0000_1280);
        check("lh_err", err, 0);
        run_req(0, 32'h8000_0003, 0, 2'd1, 1, 0, lat, rd, err);
        check("lhu_data", rd, 32'h0000_1280);
        rd_hi = 32'h0000_00FF;
        run_req(0, 32'h8000_0003, 0, 2'd1, 0, 0, lat, rd, err);
        check("lh_sext", rd, 32'hFFFF_FF80);
        run_req(0, 32'h8000_0003, 0, 2'd1, 1, 0, lat, rd, err);
        check("lhu_zext", rd, 32'h0000_FF80);

        // split sh store
        x0 = nx;
        run_req(1, 32'h8000_0003, 32'h0000_BEEF, 2'd1, 0, 0, lat, rd, err);
        check("sh_lat", lat, 5);
        check("sh_stb1", xs[x0 % 64], 4'b1000);
        check("sh_data1", xd[x0 % 64], 32'hEF00_0000);
        check("sh_stb2", xs[(x0 + 1) % 64], 4'b0001);
        check("sh_data2", xd[(x0 + 1) % 64], 32'h0000_00BE);

        // timeout with TIMEOUT=4
        rdy_base = 1'b0;
        x0 = nx; a0 = n_acc;
        run_req(0, 32'h8000_0000, 0, 2'd2, 0, 0, lat, rd, err);
        check("to_lat", lat, 6);
        check("to_err", err, 1);
        check("to_acc_cycles", n_acc - a0, 4);
        check("to_nx", nx - x0, 0);
        rdy_base = 1'b1;

        // perr on beat 1 of a split
        perr_en = 1'b1;
        s0 = n_setup;
        run_req(0, 32'h8000_0003, 0, 2'd1, 0, 0, lat, rd, err);
        check("perr_lat", lat, 3);
        check("perr_err", err, 1);
        check("perr_setups", n_setup - s0, 1);
        perr_en = 1'b0;

        // illegal dword on a 32-bit unit
        s0 = n_setup;
        run_req(0, 32'h8000_0000, 0, 2'd3, 0, 0, lat, rd, err);
        check("d32_lat", lat, 1);
        check("d32_err", err, 1);
        check("d32_setups", n_setup - s0, 0);

        // misaligned rejected when splitting is disabled
        s0 = n_ns_sel;
        run_req(0, 32'h0000_0002, 0, 2'd2, 0, 1, lat, rd, err);
        check("ns_lat", lat, 1);
        check("ns_err", err, 1);
        check("ns_no_psel", n_ns_sel - s0, 0);
        use_ns = 1'b0;

        // reset during ACCESS2
        stall_hi = 1'b1;
        rd_lo = 32'h1111_1111;
        req_write = 1'b0; req_addr = 32'h8000_0003; req_size = 2'd1; req_unsigned = 1'b0;
        rv = 1'b1;
        @(posedge clk); #1;
        rv = 1'b0;
        k = 0;
        while (!(APB_psel && APB_penable && APB_paddr[2]) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_mid_reached", APB_psel && APB_penable && APB_paddr[2], 1);
        rts = 1'b1;
        #1;
        check("rst_mid_psel", {APB_psel, APB_penable}, 0);
        check("rst_mid_resp", resp_valid, 0);
        check("rst_mid_ready", req_ready, 1);
        @(posedge clk); #1;
        rts = 1'b0; stall_hi = 1'b0;
        check("rst_mid_noresp", resp_valid, 0);
        rd_lo = 32'hCAFE_F00D;
        run_req(0, 32'h8000_0000, 0, 2'd2, 0, 0, lat, rd, err);
        check("post_rst_lat", lat, 3);
        check("post_rst_data", rd, 32'hCAFE_F00D);
        check("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
